// File: rtl/big_split_n.sv
// big_split_n: one-input, D-output packet splitter (D = NOUT network ports
// plus one local core port at index NOUT). Each destination has its own
// DEPTH-entry FIFO, so a stalled consumer only holds up traffic that
// targets it.
//
// Ports
//   CLK        rising-edge clock for all state
//   RESET      synchronous, active-high; empties all FIFOs, clears drop_cnt
//   in_data    W-bit payload
//   in_sel     SW-bit routing control (unicast index + core bit, or a D-bit mask)
//   in_valid   producer offers {in_data, in_sel}
//   in_ready   packet accepted on this edge when in_valid is also high
//   out_data   D*W flattened heads; slice d = [d*W +: W], zero when empty
//   out_valid  per-destination FIFO non-empty
//   out_ready  per-destination consumer ready
//   drop_cnt   saturating count of accepted packets with an illegal select
//   busy       any FIFO holds data
module big_split_n #(
  parameter int W     = 11,
  parameter int NOUT  = 4,
  parameter int DEPTH = 2,
  parameter int MCAST = 0,
  localparam int D    = NOUT + 1,
  localparam int SW   = (MCAST != 0) ? D : $clog2(NOUT) + 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [W-1:0]   in_data,
  input  logic [SW-1:0]  in_sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [D*W-1:0] out_data,
  output logic [D-1:0]   out_valid,
  input  logic [D-1:0]   out_ready,
  output logic [15:0]    drop_cnt,
  output logic           busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [D-1:0] sel_mask;
  logic         sel_illegal;
  logic [D-1:0] full_vec;
  logic         accept;
  logic [15:0]  drop_q, drop_d;

  // Select decode into a one-hot (unicast) or arbitrary (multicast) mask.
  // An empty mask is the illegal case in both modes.
  if (MCAST != 0) begin : g_mcast
    assign sel_mask = in_sel;
  end else begin : g_ucast
    localparam int IW = SW - 1;
    for (genvar d = 0; d < NOUT; d++) begin : g_dec
      assign sel_mask[d] = ~in_sel[SW-1] & (in_sel[IW-1:0] == IW'(d));
    end
    assign sel_mask[NOUT] = in_sel[SW-1];
  end

  assign sel_illegal = ~|sel_mask;

  // Readiness looks only at registered counts: a pop on a full FIFO this
  // cycle does not open room for a push until the next cycle. This keeps
  // out_ready off the in_ready path. An illegal select is always ready so
  // it can be consumed and counted.
  assign in_ready = ~RESET & ~|(sel_mask & full_vec);
  assign accept   = in_valid & in_ready;

  for (genvar d = 0; d < D; d++) begin : g_dest
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop, vld;

    assign vld         = (cnt_q != '0);
    assign push        = accept & sel_mask[d];
    assign pop         = vld & out_ready[d];
    assign full_vec[d] = (cnt_q == CW'(DEPTH));

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        cnt_q <= cnt_d;
      end
    end

    // Storage needs no reset: the output is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
      if (push) mem_q[wr_q] <= in_data;
    end

    assign out_valid[d]        = vld;
    assign out_data[d*W +: W]  = vld ? mem_q[rd_q] : '0;
  end

  always_comb begin
    drop_d = drop_q;
    if (accept && sel_illegal && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
  assign busy     = |out_valid;

endmodule

// File: tb/tb_big_split_n.sv
module tb_big_split_n;

  localparam int W = 11;

  logic clk;
  logic rst;

  // A: unicast, NOUT=4 (D=5, SW=3)
  logic [2:0]  a_sel;
  logic [W-1:0] a_data;
  logic        a_valid, a_irdy, a_busy;
  logic [4:0]  a_ordy, a_oval;
  logic [5*W-1:0] a_odata;
  logic [15:0] a_drop;

  // B: multicast, NOUT=4 (D=5, SW=5)
  logic [4:0]  b_sel;
  logic [W-1:0] b_data;
  logic        b_valid, b_irdy, b_busy;
  logic [4:0]  b_ordy, b_oval;
  logic [5*W-1:0] b_odata;
  logic [15:0] b_drop;

  // C: unicast, NOUT=3 (D=4, SW=3) -- index 3 with MSB=0 is illegal
  logic [2:0]  c_sel;
  logic [W-1:0] c_data;
  logic        c_valid, c_irdy, c_busy;
  logic [3:0]  c_ordy, c_oval;
  logic [4*W-1:0] c_odata;
  logic [15:0] c_drop;

  int total = 0;
  int bad   = 0;

  big_split_n #(.W(W), .NOUT(4), .DEPTH(2), .MCAST(0)) u_a (
    .CLK(clk), .RESET(rst), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
    .in_ready(a_irdy), .out_data(a_odata), .out_valid(a_oval), .out_ready(a_ordy),
    .drop_cnt(a_drop), .busy(a_busy));

  big_split_n #(.W(W), .NOUT(4), .DEPTH(2), .MCAST(1)) u_b (
    .CLK(clk), .RESET(rst), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
    .in_ready(b_irdy), .out_data(b_odata), .out_valid(b_oval), .out_ready(b_ordy),
    .drop_cnt(b_drop), .busy(b_busy));

  big_split_n #(.W(W), .NOUT(3), .DEPTH(2), .MCAST(0)) u_c (
    .CLK(clk), .RESET(rst), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
    .in_ready(c_irdy), .out_data(c_odata), .out_valid(c_oval), .out_ready(c_ordy),
    .drop_cnt(c_drop), .busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [2:0]   sel;
    logic [W-1:0] data;
    logic [4:0]   ordy;
    logic         irdy;
    logic [4:0]   oval;
    logic [2:0]   port;
    logic [W-1:0] pdata;
    logic         busy;
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle-by-cycle vectors for instance A: inputs, then the state seen in
    // that cycle before the edge (in_ready, out_valid, one slice, busy).
    //            v     sel     data     ordy      irdy  oval      port  pdata    busy
    tv[0]  = '{1'b1, 3'b001, 11'h001, 5'b11111, 1'b1, 5'b00000, 3'd1, 11'h000, 1'b0};
    tv[1]  = '{1'b1, 3'b100, 11'h7A5, 5'b11111, 1'b1, 5'b00010, 3'd1, 11'h001, 1'b1};
    tv[2]  = '{1'b0, 3'b000, 11'h000, 5'b11111, 1'b1, 5'b10000, 3'd4, 11'h7A5, 1'b1};
    tv[3]  = '{1'b0, 3'b000, 11'h000, 5'b11111, 1'b1, 5'b00000, 3'd4, 11'h000, 1'b0};
    tv[4]  = '{1'b1, 3'b000, 11'h011, 5'b11110, 1'b1, 5'b00000, 3'd0, 11'h000, 1'b0};
    tv[5]  = '{1'b1, 3'b000, 11'h022, 5'b11110, 1'b1, 5'b00001, 3'd0, 11'h011, 1'b1};
    tv[6]  = '{1'b1, 3'b000, 11'h033, 5'b11110, 1'b0, 5'b00001, 3'd0, 11'h011, 1'b1};
    tv[7]  = '{1'b1, 3'b010, 11'h0B2, 5'b11110, 1'b1, 5'b00001, 3'd0, 11'h011, 1'b1};
    tv[8]  = '{1'b1, 3'b000, 11'h033, 5'b11111, 1'b0, 5'b00101, 3'd2, 11'h0B2, 1'b1};
    tv[9]  = '{1'b1, 3'b000, 11'h033, 5'b11110, 1'b1, 5'b00001, 3'd0, 11'h022, 1'b1};
    tv[10] = '{1'b0, 3'b000, 11'h000, 5'b11111, 1'b0, 5'b00001, 3'd0, 11'h022, 1'b1};
    tv[11] = '{1'b0, 3'b000, 11'h000, 5'b11111, 1'b1, 5'b00001, 3'd0, 11'h033, 1'b1};
    tv[12] = '{1'b0, 3'b000, 11'h000, 5'b11111, 1'b1, 5'b00000, 3'd0, 11'h000, 1'b0};
    tv[13] = '{1'b1, 3'b011, 11'h133, 5'b11111, 1'b1, 5'b00000, 3'd3, 11'h000, 1'b0};
    tv[14] = '{1'b1, 3'b011, 11'h144, 5'b11111, 1'b1, 5'b01000, 3'd3, 11'h133, 1'b1};
    tv[15] = '{1'b0, 3'b011, 11'h000, 5'b00000, 1'b1, 5'b01000, 3'd3, 11'h144, 1'b1};
    tv[16] = '{1'b0, 3'b011, 11'h000, 5'b00000, 1'b1, 5'b01000, 3'd3, 11'h144, 1'b1};
    tv[17] = '{1'b0, 3'b011, 11'h000, 5'b11111, 1'b1, 5'b01000, 3'd3, 11'h144, 1'b1};
    tv[18] = '{1'b0, 3'b011, 11'h000, 5'b11111, 1'b1, 5'b00000, 3'd3, 11'h000, 1'b0};

    rst = 1'b1;
    a_valid = 1'b1; a_sel = 3'b001; a_data = 11'h0AA; a_ordy = '1;
    b_valid = 1'b0; b_sel = '0;     b_data = '0;      b_ordy = '1;
    c_valid = 1'b0; c_sel = '0;     c_data = '0;      c_ordy = '1;
    #1;
    chk("reset in_ready", a_irdy, 1'b0);
    step();
    step();
    chk("reset out_valid", a_oval, 5'b0);
    chk("reset out_data", a_odata, '0);
    chk("reset busy", a_busy, 1'b0);
    chk("reset drop_cnt", a_drop, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      a_valid = tv[i].v;
      a_sel   = tv[i].sel;
      a_data  = tv[i].data;
      a_ordy  = tv[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), a_irdy, tv[i].irdy);
      chk($sformatf("vec%0d out_valid", i), a_oval, tv[i].oval);
      chk($sformatf("vec%0d out_data[%0d]", i, tv[i].port),
          a_odata[int'(tv[i].port)*W +: W], tv[i].pdata);
      chk($sformatf("vec%0d busy", i), a_busy, tv[i].busy);
      step();
    end
    a_valid = 1'b0;

    // Multicast all-or-nothing with port 2 full.
    b_ordy = 5'b11011;
    b_valid = 1'b1; b_sel = 5'b00100; b_data = 11'h201; step();
    b_data = 11'h202; step();
    b_sel = 5'b10101; b_data = 11'h3C3;
    #1;
    chk("mc blocked in_ready", b_irdy, 1'b0);
    step();
    chk("mc blocked out_valid", b_oval, 5'b00100);
    b_ordy = 5'b11111;
    #1;
    chk("mc full+pop in_ready", b_irdy, 1'b0);
    step();
    chk("mc after pop in_ready", b_irdy, 1'b1);
    chk("mc port2 head", b_odata[2*W +: W], 11'h202);
    step();
    b_valid = 1'b0;
    #1;
    chk("mc fanout out_valid", b_oval, 5'b10101);
    chk("mc port0 data", b_odata[0 +: W], 11'h3C3);
    chk("mc port2 data", b_odata[2*W +: W], 11'h3C3);
    chk("mc port4 data", b_odata[4*W +: W], 11'h3C3);
    chk("mc port1 data", b_odata[1*W +: W], 11'h000);
    step();
    chk("mc drained busy", b_busy, 1'b0);
    b_valid = 1'b1; b_sel = 5'b00000; b_data = 11'h111;
    #1;
    chk("mc zero mask in_ready", b_irdy, 1'b1);
    step();
    b_valid = 1'b0;
    #1;
    chk("mc zero mask out_valid", b_oval, 5'b0);
    chk("mc zero mask drop_cnt", b_drop, 16'd1);

    // Unicast NOUT=3: index 3 illegal, core legal, then drop_cnt saturation.
    c_valid = 1'b1; c_sel = 3'b011; c_data = 11'h155;
    #1;
    chk("nout3 illegal in_ready", c_irdy, 1'b1);
    step();
    c_valid = 1'b0;
    #1;
    chk("nout3 illegal out_valid", c_oval, 4'b0);
    chk("nout3 illegal drop_cnt", c_drop, 16'd1);
    c_valid = 1'b1; c_sel = 3'b100; c_data = 11'h0C4;
    step();
    c_valid = 1'b0;
    #1;
    chk("nout3 core out_valid", c_oval, 4'b1000);
    chk("nout3 core data", c_odata[3*W +: W], 11'h0C4);
    chk("nout3 core drop_cnt", c_drop, 16'd1);
    step();
    c_valid = 1'b1; c_sel = 3'b011;
    repeat (65533) @(posedge clk);
    #1;
    chk("drop_cnt near max", c_drop, 16'hFFFE);
    step();
    chk("drop_cnt max", c_drop, 16'hFFFF);
    step();
    chk("drop_cnt saturated", c_drop, 16'hFFFF);
    c_valid = 1'b0;

    // Reset with two packets buffered on A.
    a_ordy = 5'b00000;
    a_valid = 1'b1; a_sel = 3'b001; a_data = 11'h101; step();
    a_data = 11'h102; step();
    a_valid = 1'b0;
    #1;
    chk("pre-reset out_valid", a_oval, 5'b00010);
    chk("pre-reset head", a_odata[1*W +: W], 11'h101);
    rst = 1'b1;
    a_valid = 1'b1; a_sel = 3'b010; a_data = 11'h3FF;
    #1;
    chk("in reset in_ready", a_irdy, 1'b0);
    step();
    chk("post-reset out_valid", a_oval, 5'b0);
    chk("post-reset busy", a_busy, 1'b0);
    chk("post-reset out_data", a_odata, '0);
    chk("post-reset drop_cnt", c_drop, 16'h0);
    rst = 1'b0;
    a_sel = 3'b001; a_data = 11'h5A5; a_ordy = 5'b11111;
    #1;
    chk("release in_ready", a_irdy, 1'b1);
    step();
    a_valid = 1'b0;
    #1;
    chk("release out_valid", a_oval, 5'b00010);
    chk("release data", a_odata[1*W +: W], 11'h5A5);
    step();
    chk("release drained", a_oval, 5'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
